// File: rtl/result_pack_fifo.sv
// result_pack_fifo: packs single-element captures from a systolic array's result lanes into
// bus-wide words and queues them in a DEPTH-entry FIFO for a downstream consumer.
// Optional feature: define RESULT_PACK_FLUSH_EN to add flush_i, which emits a partial word
// with its unfilled upper slots zeroed.
module result_pack_fifo #(
  parameter int unsigned ARRAY_WIDTH = 4,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned BUS_WIDTH   = 256,
  parameter int unsigned DEPTH       = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
`ifdef RESULT_PACK_FLUSH_EN
  input  logic                          flush_i,
`endif
  input  logic                          array_reset_n [ARRAY_WIDTH],
  input  logic [DATA_WIDTH-1:0]         array_results [ARRAY_WIDTH],
  output logic [BUS_WIDTH-1:0]          data_o,
  output logic                          valid_o,
  input  logic                          accepted_i,
  output logic                          full_o,
  output logic [$clog2(DEPTH):0]        level_o,
  output logic                          overflow_o
);

  localparam int unsigned ELEMS = BUS_WIDTH / DATA_WIDTH;
  localparam int unsigned CNT_W = $clog2(ELEMS);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic                  cap_valid;
  logic [DATA_WIDTH-1:0] cap_data;
  logic [BUS_WIDTH-1:0]  pack_q, pack_d, pack_fill;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  push, pop, wr_en, ovf_set;
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]      level_q, level_d;
  logic                  overflow_q;
  logic [BUS_WIDTH-1:0]  mem_q [DEPTH];

  // Select the element from the lowest-index lane whose strobe is low.
  always_comb begin
    cap_valid = 1'b0;
    cap_data  = '0;
    for (int i = int'(ARRAY_WIDTH) - 1; i >= 0; i--) begin
      if (!array_reset_n[i]) begin
        cap_valid = 1'b1;
        cap_data  = array_results[i];
      end
    end
  end

  // Merge the captured element into the pack word and decide whether a word is pushed.
  always_comb begin
    pack_fill = pack_q;
    if (cap_valid) begin
      pack_fill[int'(cnt_q) * DATA_WIDTH +: DATA_WIDTH] = cap_data;
    end
`ifdef RESULT_PACK_FLUSH_EN
    // A flush with nothing captured and nothing pending has nothing to emit.
    push = (cap_valid && (cnt_q == CNT_W'(ELEMS - 1))) ||
           (flush_i && (cap_valid || (cnt_q != '0)));
`else
    push = cap_valid && (cnt_q == CNT_W'(ELEMS - 1));
`endif
    pack_d = pack_q;
    cnt_d  = cnt_q;
    if (push) begin
      pack_d = '0;
      cnt_d  = '0;
    end else if (cap_valid) begin
      pack_d = pack_fill;
      cnt_d  = cnt_q + 1'b1;
    end
  end

  // FIFO control: a pop in the same cycle frees the slot a push into a full FIFO needs.
  always_comb begin
    pop     = valid_o && accepted_i;
    wr_en   = push && (!full_o || pop);
    ovf_set = push && full_o && !pop;
    level_d = level_q + LVL_W'(wr_en) - LVL_W'(pop);
  end

  // Pack register, pack count, pointers, level and sticky overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pack_q     <= '0;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      pack_q  <= pack_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (ovf_set) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Storage array; cleared on reset so data_o reads zero while reset is held.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wr_ptr_q] <= pack_fill;
    end
  end

  // Outputs are derived purely from registered state.
  always_comb begin
    data_o     = mem_q[rd_ptr_q];
    valid_o    = (level_q != '0);
    full_o     = (level_q == LVL_W'(DEPTH));
    level_o    = level_q;
    overflow_o = overflow_q;
  end

endmodule

// File: tb/tb_result_pack_fifo.sv
// Bench for result_pack_fifo: directed and random captures checked against a queue-based
// model of packing and FIFO behaviour. Define RESULT_PACK_FLUSH_EN to also exercise flush_i.
module tb_result_pack_fifo;

  localparam int AW    = 4;
  localparam int DW    = 16;
  localparam int BW    = 256;
  localparam int DEPTH = 16;
  localparam int ELEMS = BW / DW;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          flush;
  logic          strb [AW];
  logic [DW-1:0] res [AW];
  logic [BW-1:0] data_o;
  logic          valid_o;
  logic          acc;
  logic          full_o;
  logic [4:0]    level_o;
  logic          overflow_o;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state
  logic [BW-1:0] q[$];
  logic [DW-1:0] pe[$];
  logic          ovf;

  always #5 clk = ~clk;

  result_pack_fifo #(
    .ARRAY_WIDTH(AW),
    .DATA_WIDTH (DW),
    .BUS_WIDTH  (BW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
`ifdef RESULT_PACK_FLUSH_EN
    .flush_i      (flush),
`endif
    .array_reset_n(strb),
    .array_results(res),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .accepted_i   (acc),
    .full_o       (full_o),
    .level_o      (level_o),
    .overflow_o   (overflow_o)
  );

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
  endtask

  task automatic check_all();
    chk("valid", BW'(valid_o), BW'(q.size() != 0));
    chk("level", BW'(level_o), BW'(q.size()));
    chk("full", BW'(full_o), BW'(q.size() == DEPTH));
    chk("overflow", BW'(overflow_o), BW'(ovf));
    if (q.size() != 0) chk("data", data_o, q[0]);
  endtask

  // Model one clock edge from the currently driven inputs, then sample after the edge.
  task automatic tick();
    logic          cap = 1'b0;
    logic [DW-1:0] e = '0;
    logic [BW-1:0] w;
    logic          do_push;
    logic          do_pop;
    for (int i = 0; i < AW; i++) begin
      if (!strb[i] && !cap) begin
        cap = 1'b1;
        e   = res[i];
      end
    end
    do_pop = (q.size() != 0) && acc;
    if (cap) pe.push_back(e);
    do_push = (pe.size() == ELEMS);
`ifdef RESULT_PACK_FLUSH_EN
    if (flush && pe.size() != 0) do_push = 1'b1;
`endif
    w = '0;
    if (do_push) begin
      foreach (pe[k]) w[k*DW +: DW] = pe[k];
      pe.delete();
    end
    if (do_pop) void'(q.pop_front());
    if (do_push) begin
      if (q.size() < DEPTH) q.push_back(w);
      else ovf = 1'b1;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < AW; i++) begin
      strb[i] = 1'b1;
      res[i]  = DW'($urandom);
    end
    acc   = 1'b0;
    flush = 1'b0;
  endtask

  task automatic cap_lane(input int lane, input logic [DW-1:0] val, input logic a);
    idle_inputs();
    strb[lane] = 1'b0;
    res[lane]  = val;
    acc        = a;
    tick();
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    #2;
    q.delete();
    pe.delete();
    ovf = 1'b0;
    chk("rst_data", data_o, '0);
    chk("rst_valid", BW'(valid_o), '0);
    chk("rst_full", BW'(full_o), '0);
    chk("rst_level", BW'(level_o), '0);
    chk("rst_ovf", BW'(overflow_o), '0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    ovf     = 1'b0;
    idle_inputs();
    #1;
    do_reset();

    // Sixteen captures on lane 2 with ascending values.
    for (int i = 1; i <= ELEMS; i++) cap_lane(2, DW'(i), 1'b0);
    chk("pack_slot0", BW'(data_o[15:0]), BW'(16'h0001));
    chk("pack_slot15", BW'(data_o[255:240]), BW'(16'h0010));
    chk("pack_level1", BW'(level_o), BW'(1));

    // Two lanes strobed together: lower lane wins.
    idle_inputs();
    strb[1] = 1'b0; res[1] = 16'hAAAA;
    strb[3] = 1'b0; res[3] = 16'hBBBB;
    tick();
    for (int i = 1; i < ELEMS; i++) cap_lane(0, DW'($urandom), 1'b0);
    idle_inputs();
    acc = 1'b1;
    tick();
    chk("lane_prio", BW'(data_o[15:0]), BW'(16'hAAAA));

    // Fill to full, then overflow, then push-with-pop at full.
    while (q.size() < DEPTH) cap_lane($urandom_range(0, AW - 1), DW'($urandom), 1'b0);
    chk("full_flag", BW'(full_o), BW'(1));
    for (int i = 0; i < ELEMS; i++) cap_lane(1, DW'($urandom), 1'b0);
    chk("ovf_set", BW'(overflow_o), BW'(1));
    chk("ovf_level", BW'(level_o), BW'(DEPTH));
    for (int i = 0; i < ELEMS; i++) cap_lane(3, DW'($urandom), (i == ELEMS - 1));
    chk("pushpop_full", BW'(level_o), BW'(DEPTH));

    // Twenty words with a pop every other cycle; pointers wrap.
    do_reset();
    for (int c = 0; c < 20 * ELEMS; c++) cap_lane(c % AW, DW'($urandom), c[0]);
    idle_inputs();
    acc = 1'b1;
    while (q.size() != 0) tick();

    // Random strobes, data and accepts.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < AW; i++) begin
        strb[i] = ($urandom_range(0, 3) != 0);
        res[i]  = DW'($urandom);
      end
      acc = ($urandom_range(0, 2) == 0);
`ifdef RESULT_PACK_FLUSH_EN
      flush = ($urandom_range(0, 15) == 0);
`endif
      tick();
    end

`ifdef RESULT_PACK_FLUSH_EN
    // Partial flush zero-fills the upper slots; an empty flush is a no-op.
    do_reset();
    for (int i = 1; i <= 5; i++) cap_lane(0, DW'(i), 1'b0);
    idle_inputs();
    flush = 1'b1;
    tick();
    chk("flush_low", BW'(data_o[79:0]), BW'(80'h0005_0004_0003_0002_0001));
    chk("flush_zero", BW'(data_o[255:80]), '0);
    idle_inputs();
    flush = 1'b1;
    tick();
    chk("flush_noop", BW'(level_o), BW'(1));
`endif

    // Reset mid-operation discards stored and partial words.
    do_reset();
    for (int i = 0; i < 3 * ELEMS + 7; i++) cap_lane(2, DW'($urandom), 1'b0);
    chk("pre_rst_level", BW'(level_o), BW'(3));
    do_reset();
    for (int i = 0; i < ELEMS - 1; i++) cap_lane(1, DW'($urandom), 1'b0);
    chk("post_rst_empty", BW'(valid_o), BW'(0));
    cap_lane(1, DW'($urandom), 1'b0);
    chk("post_rst_word", BW'(valid_o), BW'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
